// File: rtl/segway_pkg.sv
// Shared types and default channel map for the A2D conversion scheduler.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package segway_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WAIT_CMD,
        GAP,
        READ,
        WAIT_RD
    } a2d_state_t;

    typedef logic [11:0] a2d_val_t;

    localparam logic [2:0] A2D_CH_LFT   = 3'd0;
    localparam logic [2:0] A2D_CH_RGHT  = 3'd4;
    localparam logic [2:0] A2D_CH_STEER = 3'd5;
    localparam logic [2:0] A2D_CH_BATT  = 3'd6;

    // Command word for a conversion of the given A2D channel.
    function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
        return {2'b00, chnl, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_rr_regs.sv
// Round-robin channel index, channel number decode and the four result registers.
// Latency: a write lands on the edge where wr_en is sampled; rr advances on that same edge.
// Backpressure: none; wr_en is accepted unconditionally.
module a2d_rr_regs
    import segway_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = A2D_CH_LFT,
    parameter logic [2:0] CH_RGHT  = A2D_CH_RGHT,
    parameter logic [2:0] CH_STEER = A2D_CH_STEER,
    parameter logic [2:0] CH_BATT  = A2D_CH_BATT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [11:0] wr_dat,
    output logic [1:0]  rr,
    output logic [2:0]  chnl,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt
);

    // Map the round-robin slot onto the physical A2D channel number.
    always_comb begin
        chnl = CH_LFT;
        case (rr)
            2'd0:    chnl = CH_LFT;
            2'd1:    chnl = CH_RGHT;
            2'd2:    chnl = CH_STEER;
            default: chnl = CH_BATT;
        endcase
    end

    // Slot advances only once a result has been stored, wrapping 3 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr <= 2'd0;
        else if (wr_en)
            rr <= rr + 2'd1;
    end

    // Store the new result into the register owned by the current slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else if (wr_en) begin
            case (rr)
                2'd0:    lft_ld    <= a2d_val_t'(wr_dat);
                2'd1:    rght_ld   <= a2d_val_t'(wr_dat);
                2'd2:    steer_pot <= a2d_val_t'(wr_dat);
                default: batt      <= a2d_val_t'(wr_dat);
            endcase
        end
    end

endmodule

// File: rtl/a2d_sched.sv
// Round-robin scheduler driving two SPI transactions per conversion (channel select, then read).
// Latency: wrt one cycle after nxt; cnv_cmplt 2T+4 cycles after nxt for a T-cycle SPI transaction.
// Backpressure: none; nxt outside IDLE is dropped, and a missing done stalls the FSM until reset.
module a2d_sched
    import segway_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = A2D_CH_LFT,
    parameter logic [2:0] CH_RGHT  = A2D_CH_RGHT,
    parameter logic [2:0] CH_STEER = A2D_CH_STEER,
    parameter logic [2:0] CH_BATT  = A2D_CH_BATT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        sweep_done
);

    a2d_state_t  state;
    logic [1:0]  rr;
    logic [2:0]  chnl;
    logic        res_wr;

    // Only 12 result bits exist; the converter's upper nibble carries nothing useful.
    logic        unused_resp_hi;
    assign unused_resp_hi = ^resp[15:12];

    // A result is captured only on the done that closes the read transaction.
    assign res_wr = (state == WAIT_RD) && done;

    a2d_rr_regs #(
        .CH_LFT   (CH_LFT),
        .CH_RGHT  (CH_RGHT),
        .CH_STEER (CH_STEER),
        .CH_BATT  (CH_BATT)
    ) u_regs (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (res_wr),
        .wr_dat    (resp[11:0]),
        .rr        (rr),
        .chnl      (chnl),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt)
    );

    // Conversion sequencer; wrt/cmd/pulses are registered on state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wrt        <= 1'b0;
            cmd        <= 16'h0000;
            cnv_cmplt  <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            wrt        <= 1'b0;
            cnv_cmplt  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt) begin
                        state <= CMD;
                        wrt   <= 1'b1;
                        cmd   <= a2d_cmd(chnl);
                    end
                end
                CMD: begin
                    state <= WAIT_CMD;
                end
                WAIT_CMD: begin
                    // First transaction only selects the channel; its data is stale.
                    if (done)
                        state <= GAP;
                end
                GAP: begin
                    // Dead cycle lets the SPI master deassert SS_n between frames.
                    state <= READ;
                    wrt   <= 1'b1;
                end
                READ: begin
                    state <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (done) begin
                        state      <= IDLE;
                        cnv_cmplt  <= 1'b1;
                        sweep_done <= (rr == 2'd3);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// Randomised scoreboard bench for a2d_sched with a behavioural SPI master and channel model.
// Latency: n/a.
// Backpressure: n/a.
module tb_a2d_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] resp = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt, sweep_done;

    a2d_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nxt        (nxt),
        .wrt        (wrt),
        .cmd        (cmd),
        .done       (done),
        .resp       (resp),
        .lft_ld     (lft_ld),
        .rght_ld    (rght_ld),
        .steer_pot  (steer_pot),
        .batt       (batt),
        .cnv_cmplt  (cnv_cmplt),
        .sweep_done (sweep_done)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] cmd;
        int          gap;
    } exp_wrt_t;

    typedef struct {
        logic [11:0] l, r, s, b;
        logic        sw;
        int          cyc;
    } exp_res_t;

    exp_wrt_t wq[$];
    exp_res_t rq[$];

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: channel order, latest result per slot, current slot.
    logic [2:0]  chan_tbl [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [11:0] m_res [4];
    int          m_rr = 0;
    int          n_cnv_exp = 0;
    int          n_cnv_seen = 0;
    int          n_wrt_seen = 0;
    int          last_wrt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops expectations whenever the DUT presents wrt or cnv_cmplt.
    exp_wrt_t ew;
    exp_res_t er;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wrt) begin
                n_wrt_seen++;
                check("wrt_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    ew = wq.pop_front();
                    check("cmd", cmd, ew.cmd);
                    if (ew.gap >= 0)
                        check("wrt_spacing", cyc - last_wrt, ew.gap);
                end
                last_wrt = cyc;
            end
            if (cnv_cmplt) begin
                n_cnv_seen++;
                check("cnv_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    er = rq.pop_front();
                    check("lft_ld", lft_ld, er.l);
                    check("rght_ld", rght_ld, er.r);
                    check("steer_pot", steer_pot, er.s);
                    check("batt", batt, er.b);
                    check("sweep_done", sweep_done, er.sw);
                    check("cnv_latency", cyc, er.cyc);
                end
            end
            if (sweep_done)
                check("sweep_with_cnv", cnv_cmplt, 1);
        end
    end

    // Predict both command words and the resulting register image for one conversion.
    task automatic model_issue(input int t, input logic [15:0] rd, input int nxt_c);
        exp_wrt_t w;
        exp_res_t r;
        w.cmd = 16'(chan_tbl[m_rr]) << 11;
        w.gap = -1;
        wq.push_back(w);
        w.gap = t + 2;
        wq.push_back(w);
        m_res[m_rr] = rd[11:0];
        r.l   = m_res[0];
        r.r   = m_res[1];
        r.s   = m_res[2];
        r.b   = m_res[3];
        r.sw  = (m_rr == 3);
        r.cyc = nxt_c + 2 * t + 4;
        rq.push_back(r);
        m_rr = (m_rr + 1) % 4;
        n_cnv_exp++;
    endtask

    task automatic wait_wrt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wrt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok)
            check("wrt_timeout", wrt, 1);
    endtask

    // SPI master: answer a wrt exactly t cycles later; optionally inject noise.
    task automatic spi_xfer(input int t, input logic [15:0] r, input bit disturb);
        for (int i = 0; i < t; i++) begin
            @(posedge clk); #1;
            nxt = disturb && (i == 3);
        end
        done = 1'b1;
        resp = r;
    endtask

    // Called at posedge+1; returns at posedge+1 of the cnv_cmplt cycle.
    task automatic convert(input int t, input logic [15:0] junk, input logic [15:0] rd,
                           input bit disturb, input bit abort);
        bit ok;
        nxt = 1'b1;
        if (abort) begin
            exp_wrt_t w;
            w.cmd = 16'(chan_tbl[m_rr]) << 11;
            w.gap = -1;
            wq.push_back(w);
            w.gap = t + 2;
            wq.push_back(w);
        end else begin
            model_issue(t, rd, cyc);
        end
        @(posedge clk); #1;
        nxt = 1'b0;
        wait_wrt(ok);
        if (!ok) return;
        spi_xfer(t, junk, disturb);
        @(posedge clk); #1;
        done = disturb;
        resp = 16'($urandom);
        nxt  = disturb;
        @(posedge clk); #1;
        done = 1'b0;
        nxt  = 1'b0;
        wait_wrt(ok);
        if (!ok) return;
        if (abort) begin
            repeat (5) @(posedge clk);
            #1;
            rst_n = 1'b0;
            for (int i = 0; i < 4; i++) m_res[i] = 12'h000;
            m_rr = 0;
            repeat (3) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            done = 1'b1;
            resp = 16'h0ABC;
        end else begin
            spi_xfer(t, rd, disturb);
        end
        @(posedge clk); #1;
        done = 1'b0;
        resp = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) m_res[i] = 12'h000;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wrt", wrt, 0);
        check("rst_cmd", cmd, 16'h0000);
        check("rst_lft", lft_ld, 0);
        check("rst_rght", rght_ld, 0);
        check("rst_steer", steer_pot, 0);
        check("rst_batt", batt, 0);
        check("rst_cnv", cnv_cmplt, 0);
        check("rst_sweep", sweep_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle with no requests; a stray done in IDLE must be ignored.
        idle(50);
        done = 1'b1;
        resp = 16'h0FFF;
        idle(1);
        done = 1'b0;
        idle(49);
        check("idle_no_wrt", n_wrt_seen, 0);
        check("idle_lft", lft_ld, 0);
        check("idle_cmd", cmd, 16'h0000);

        // Single conversion, 32-cycle SPI, then finish the first sweep.
        convert(32, 16'hF123, 16'hF123, 1'b0, 1'b0);
        idle(3);
        convert(32, 16'h1234, 16'h0AAA, 1'b0, 1'b0);
        convert(32, 16'h1234, 16'h0BBB, 1'b0, 1'b0);
        convert(32, 16'h1234, 16'h0CCC, 1'b0, 1'b0);

        // Full back-to-back sweep with distinct values per channel.
        convert(32, 16'hFFFF, 16'h0111, 1'b0, 1'b0);
        convert(32, 16'hFFFF, 16'h0222, 1'b0, 1'b0);
        convert(32, 16'hFFFF, 16'h0333, 1'b0, 1'b0);
        convert(32, 16'hFFFF, 16'h0444, 1'b0, 1'b0);

        // Wrap to channel 0 with extra nxt pulses and a spurious done in GAP.
        idle(2);
        convert(32, 16'hEEEE, 16'h0555, 1'b1, 1'b0);
        idle(2);
        check("wrap_lft", lft_ld, 12'h555);

        // Reset during WAIT_RD; the late done must not write anything.
        convert(20, 16'h1111, 16'h0ABC, 1'b0, 1'b1);
        idle(3);
        check("abort_lft", lft_ld, 0);
        check("abort_rght", rght_ld, 0);
        check("abort_batt", batt, 0);
        check("abort_cmd", cmd, 16'h0000);

        // Randomised conversions.
        for (int k = 0; k < 24; k++) begin
            int t;
            t = $urandom_range(40, 5);
            convert(t, 16'($urandom), 16'($urandom), 1'($urandom_range(1, 0)), 1'b0);
            idle($urandom_range(3, 0));
        end

        idle(10);
        check("wrt_queue_empty", wq.size(), 0);
        check("res_queue_empty", rq.size(), 0);
        check("cnv_count", n_cnv_seen, n_cnv_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
- Round-robin conversion scheduler for the shared SPI A2D converter.
- Sequences conversions of four channels (left load cell, right load cell, steering pot, battery) through the SPI master's wrt/done handshake.
- Holds the latest 12-bit result for each channel.
- Its lft_ld/rght_ld outputs feed the steering-enable logic directly; steer_pot and batt feed balance control and the battery monitor.

Parameters:
- CH_LFT, 3'd0, A2D channel number for the left load cell
- CH_RGHT, 3'd4, A2D channel number for the right load cell
- CH_STEER, 3'd5, A2D channel number for the steering potentiometer
- CH_BATT, 3'd6, A2D channel number for the battery divider

Ports:
- clk  in  1  system clock (50MHz)
- rst_n  in  1  asynchronous active-low reset
- nxt  in  1  one-cycle request: start conversion of the current round-robin channel
- wrt  out  1  one-cycle pulse to SPI master starting a 16-bit transaction
- cmd  out  16  command word to SPI master
- done  in  1  one-cycle pulse from SPI master: transaction complete
- resp  in  16  data returned by SPI master, valid while done=1
- lft_ld  out  12  latest left load result
- rght_ld  out  12  latest right load result
- steer_pot  out  12  latest steering pot result
- batt  out  12  latest battery result
- cnv_cmplt  out  1  one-cycle pulse: a result register was updated
- sweep_done  out  1  one-cycle pulse, coincident with cnv_cmplt, when the batt result is written

Behaviour:
- Reset:
  - State IDLE, rr=0, wrt=0, cmd=16'h0000, all result registers 12'h000, cnv_cmplt=0, sweep_done=0.
  - Reset mid-transaction abandons the transaction with no result write.
  - A done arriving after reset, while in IDLE, is ignored.
- Channel select:
  - rr is a 2-bit round-robin index: 0→CH_LFT, 1→CH_RGHT, 2→CH_STEER, 3→CH_BATT.
  - rr advances only after a successful result write; it wraps 3→0.
- Command word: cmd = {2'b00, chnl[2:0], 11'h000}, held stable from the wrt cycle through done.
- State machine (all outputs registered):
  - IDLE: nxt=1 → CMD.
  - CMD: wrt=1 for exactly this cycle → WAIT_CMD.
  - WAIT_CMD: wait for done; the resp from this transaction is discarded. done → GAP.
  - GAP: exactly one dead cycle, letting the SPI master return its SS_n high → READ.
  - READ: wrt=1 for one cycle, same cmd → WAIT_RD.
  - WAIT_RD: on the done edge, resp[11:0] is written to the register selected by rr and rr increments → IDLE.
- Completion pulses:
  - cnv_cmplt is high during the cycle after that done (the first IDLE cycle); the new value is visible that same cycle.
  - sweep_done also pulses in that cycle when the written channel was rr=3.
- Latency: with nxt at cycle 0, the first wrt is at cycle 1. If the SPI master takes T cycles per transaction, cnv_cmplt is at cycle 2T+4.
- Simultaneous and boundary events:
  - nxt while not IDLE is ignored, with no queueing.
  - nxt in the same cycle as the cnv_cmplt IDLE cycle is accepted.
  - done in CMD, GAP, READ or IDLE is ignored.
  - resp[15:12] is ignored.
- No timeout. A missing done holds the state in WAIT_CMD or WAIT_RD until reset.

Decomposition:
- Shared package segway_pkg:
  - typedef enum a2d_state_t {IDLE, CMD, WAIT_CMD, GAP, READ, WAIT_RD}
  - typedef logic [11:0] a2d_val_t
  - localparam values for the default channel numbers
- One sub-module, a2d_rr_regs: the rr counter, the channel decode and the four result registers with a write enable. The FSM lives in a2d_sched.

Test Plan:
- Reset, then idle for 100 cycles, no nxt → wrt never asserted; all outputs 12'h000; cmd=16'h0000.
- SPI model (done 32 cycles after wrt, resp=16'hF123), one nxt → exactly two wrt pulses, each with cmd=16'h0000, separated by 34 cycles. Then lft_ld=12'h123, cnv_cmplt one pulse, rr=1.
- Four nxt pulses, resp values 16'h0111/16'h0222/16'h0333/16'h0444 on the second transaction of each → lft_ld=111, rght_ld=222, steer_pot=333, batt=444. Commands were 16'h0000, 16'h2000, 16'h2800, 16'h3000. sweep_done pulses once, on the fourth.
- Extra nxt pulses mid-transaction, plus a spurious done during GAP → still exactly two wrt pulses per conversion; the result is unchanged from the non-disturbed run.
- Fifth nxt after a sweep → cmd=16'h0000 again (wrap), and lft_ld updates.
- rst_n low during WAIT_RD, released, then the pending done arrives → no register write, no cnv_cmplt; the next nxt converts channel 0.
